// File: rtl/seq_mult_ctrl_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// The master side issues start with operands; the slave side returns the result and status.
interface seq_mult_ctrl_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        data_ready;
  logic        data_exception;
  logic        busy;

  modport master (
    output start,
    output a,
    output b,
    input  result,
    input  data_ready,
    input  data_exception,
    input  busy
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output result,
    output data_ready,
    output data_exception,
    output busy
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequential signed 32x32 multiplier: radix-2 Booth, one iteration per cycle,
// with every add/subtract going through a single shared carry-lookahead adder.

module cla_full_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s
);
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups, group carries chained through group generate/propagate.
  always_comb begin
    logic carry;
    logic grp_g;
    logic grp_p;
    c     = '0;
    carry = cin;
    for (int i = 0; i < 8; i++) begin
      c[4*i]   = carry;
      c[4*i+1] = g[4*i] | (p[4*i] & carry);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & carry);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & carry);
      grp_g    = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      grp_p    = &p[4*i +: 4];
      carry    = grp_g | (grp_p & carry);
    end
  end

  assign s = p ^ c;
endmodule

module seq_mult_ctrl (
  input logic            clock,
  input logic            reset_n,
  seq_mult_ctrl_if.slave mul_io
);
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic        q1_q, q1_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        ready_q, ready_d;

  logic [1:0]  booth_pair;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] sum;
  logic        ovf;
  logic        sum_sign;
  logic [31:0] p_hi_shift;
  logic [31:0] p_lo_shift;
  logic        accept;

  always_comb begin
    booth_pair = {p_lo_q[0], q1_q};
    add_b      = '0;
    add_cin    = 1'b0;
    unique case (booth_pair)
      2'b01:   add_b = m_q;
      2'b10: begin
        add_b   = ~m_q;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  cla_full_adder u_adder (
    .a   (p_hi_q),
    .b   (add_b),
    .cin (add_cin),
    .s   (sum)
  );

  // The 32-bit sum can overflow (e.g. 0 - 0x80000000); shift in the true sign so
  // P_hi stays exact and the overflow flag sees the real upper half.
  assign ovf        = (p_hi_q[31] == add_b[31]) && (sum[31] != p_hi_q[31]);
  assign sum_sign   = sum[31] ^ ovf;
  assign p_hi_shift = {sum_sign, sum[31:1]};
  assign p_lo_shift = {sum[0], p_lo_q[31:1]};

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    ready_d  = 1'b0;
    accept   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mul_io.start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        p_hi_d = p_hi_shift;
        p_lo_d = p_lo_shift;
        q1_d   = p_lo_q[0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = StDone;
          result_d = p_lo_shift;
          exc_d    = (p_hi_shift != {32{p_lo_shift[31]}});
        end
      end
      StDone: begin
        ready_d = 1'b1;
        if (mul_io.start) begin
          accept  = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      m_d    = mul_io.a;
      p_hi_d = '0;
      p_lo_d = mul_io.b;
      q1_d   = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      m_q      <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      ready_q  <= ready_d;
    end
  end

  assign mul_io.result         = result_q;
  assign mul_io.data_ready     = ready_q;
  assign mul_io.data_exception = exc_q;
  assign mul_io.busy           = (state_q == StRun);
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: products, overflow flag, latency, busy width,
// start-while-busy, mid-run reset and back-to-back operation.
module tb_seq_mult_ctrl;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  seq_mult_ctrl_if mul_if ();

  seq_mult_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mul_io  (mul_if)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_result"}, mul_if.result, 32'h0);
    check_eq({tag, "_ready"}, {31'b0, mul_if.data_ready}, 32'h0);
    check_eq({tag, "_exc"}, {31'b0, mul_if.data_exception}, 32'h0);
    check_eq({tag, "_busy"}, {31'b0, mul_if.busy}, 32'h0);
  endtask

  // Called at a falling edge; the next rising edge accepts the operation.
  // inj_n >= 0 pulses start with a=1,b=1 while the operation is in flight.
  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_res, input logic exp_exc, input int inj_n);
    int n;
    int busy_cnt;
    mul_if.a     = op_a;
    mul_if.b     = op_b;
    mul_if.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mul_if.start = 1'b0;
    mul_if.a     = 32'hDEAD_BEEF;
    mul_if.b     = 32'h1234_5678;
    n        = 0;
    busy_cnt = 0;
    while (!mul_if.data_ready && n < 80) begin
      if (mul_if.busy) busy_cnt++;
      if (n == inj_n) begin
        mul_if.start = 1'b1;
        mul_if.a     = 32'd1;
        mul_if.b     = 32'd1;
      end else begin
        mul_if.start = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    mul_if.start = 1'b0;
    check_eq({tag, "_latency"}, n, 32'd33);
    check_eq({tag, "_busy_cycles"}, busy_cnt, 32'd32);
    check_eq({tag, "_result"}, mul_if.result, exp_res);
    check_eq({tag, "_exc"}, {31'b0, mul_if.data_exception}, {31'b0, exp_exc});
    @(negedge clock);
    check_eq({tag, "_pulse_end"}, {31'b0, mul_if.data_ready}, 32'h0);
    check_eq({tag, "_result_held"}, mul_if.result, exp_res);
  endtask

  initial begin
    int n;
    int ready_seen;
    mul_if.start = 1'b0;
    mul_if.a     = '0;
    mul_if.b     = '0;

    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    run_op("mul_6x7", 32'd6, 32'd7, 32'd42, 1'b0, -1);
    run_op("mul_m3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, -1);
    run_op("mul_m2xm2", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd4, 1'b0, -1);
    run_op("ovf_2p30x4", 32'h4000_0000, 32'd4, 32'h0000_0000, 1'b1, -1);
    run_op("ovf_minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1);
    run_op("busy_start_9x9", 32'd9, 32'd9, 32'd81, 1'b0, 10);

    // Reset during iteration 20: everything clears at once, no completion pulse.
    mul_if.a     = 32'd5;
    mul_if.b     = 32'd5;
    mul_if.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mul_if.start = 1'b0;
    repeat (20) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mul_if.data_ready) ready_seen++;
    end
    check_eq("midrun_no_ready", ready_seen, 32'd0);
    reset_n = 1'b1;
    run_op("after_reset_2x3", 32'd2, 32'd3, 32'd6, 1'b0, -1);

    // start held high: completions at k+33 and k+66.
    mul_if.a     = 32'd100;
    mul_if.b     = 32'd100;
    mul_if.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mul_if.a = 32'd0;
    mul_if.b = 32'd5;
    n = 0;
    while (!mul_if.data_ready && n < 80) begin
      @(negedge clock);
      n++;
    end
    check_eq("b2b_first_latency", n, 32'd33);
    check_eq("b2b_first_result", mul_if.result, 32'd10000);
    check_eq("b2b_first_exc", {31'b0, mul_if.data_exception}, 32'h0);
    check_eq("b2b_rerun_busy", {31'b0, mul_if.busy}, 32'h1);
    @(negedge clock);
    n++;
    while (!mul_if.data_ready && n < 120) begin
      if (n >= 40) mul_if.start = 1'b0;
      @(negedge clock);
      n++;
    end
    check_eq("b2b_second_latency", n, 32'd66);
    check_eq("b2b_second_result", mul_if.result, 32'd0);
    check_eq("b2b_second_exc", {31'b0, mul_if.data_exception}, 32'h0);
    mul_if.start = 1'b0;
    repeat (40) @(negedge clock);
    check_eq("final_idle_busy", {31'b0, mul_if.busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits to match the shared cla_full_adder.
REQ-002 clock  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiply; sampled only while busy=0.
REQ-005 a  input  32  multiplicand, two's complement; captured when start is accepted.
REQ-006 b  input  32  multiplier, two's complement; captured when start is accepted.
REQ-007 result  output  32  low 32 bits of the signed product; registered.
REQ-008 data_ready  output  1  single-cycle pulse marking a valid result.
REQ-009 data_exception  output  1  signed overflow flag for the 32-bit result; valid with data_ready and held afterwards.
REQ-010 busy  output  1  high while an operation is in progress.

Function
REQ-011 The block SHALL compute the signed product with radix-2 Booth iteration, sequencing one shared cla_full_adder(a, b, cin, s) instance for every add and subtract.
REQ-012 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 Transitions SHALL be: IDLE->RUN on start; RUN->DONE after the 32nd iteration; DONE->IDLE after one cycle, or DONE->RUN if start is high in DONE.
REQ-014 On start acceptance the block SHALL load M=a, P_hi=0, P_lo=b and q_1=0, and clear the 5-bit iteration counter.
REQ-015 Each RUN cycle SHALL examine {P_lo[0], q_1}:
  - 01: P_hi = P_hi + M (adder cin=0).
  - 10: P_hi = P_hi + ~M (adder cin=1).
  - 00 or 11: no add.
REQ-016 Each RUN cycle SHALL then arithmetic-right-shift {P_hi, P_lo, q_1} by one and increment the counter.
REQ-017 The counter SHALL wrap from 31 to 0 on the final iteration; that wrap triggers RUN->DONE.
REQ-018 The add result and the shift SHALL complete in the same cycle; adder carry-out is discarded.
REQ-019 Latency: if start is accepted at rising edge k, data_ready SHALL be high exactly in the cycle between edges k+33 and k+34.
REQ-020 result SHALL equal P_lo from entry into DONE onward and SHALL hold until the next accepted start.
REQ-021 data_exception SHALL be 1 unless all 32 bits of P_hi equal P_lo[31]; it is updated on entry to DONE and held until the next accepted start.
REQ-022 busy SHALL be 1 in RUN only; start is ignored while busy=1 and the captured operands SHALL NOT change.
REQ-023 Changes on a or b after acceptance SHALL NOT affect the operation in flight.
REQ-024 start held high continuously SHALL produce back-to-back operations with a period of 33 cycles (DONE->RUN).

Reset
REQ-025 While reset_n=0, the FSM SHALL be in IDLE and result, data_ready, data_exception, busy and all internal registers SHALL be 0, independent of clock.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no data_ready pulse; the first start after release SHALL behave per REQ-019.
REQ-027 start sampled at the first rising edge after reset_n rises SHALL be accepted.

Verification
REQ-028 a=6, b=7, start one cycle -> busy high 32 cycles, then data_ready one cycle with result=42 and data_exception=0, exactly 33 edges after acceptance.
REQ-029 a=-3, b=5 -> result=0xFFFFFFF1 (-15), data_exception=0; then a=-2, b=-2 -> result=4, data_exception=0.
REQ-030 a=0x40000000, b=4 -> result=0x00000000 with data_exception=1; a=0x80000000, b=-1 -> result=0x80000000 with data_exception=1.
REQ-031 start pulsed again with a=1, b=1 at iteration 10 of an operation with a=9, b=9 -> ignored; result=81 at the normal time and busy is not extended.
REQ-032 reset_n dropped at iteration 20 -> all outputs 0 immediately and no data_ready; after release, a=2, b=3 -> result=6 after 33 cycles.
REQ-033 start held high with operands 100*100, then 0*5 -> data_ready at k+33 (10000) and k+66 (0), with data_exception=0 both times.
